// File: rtl/decode_pkg.sv
// Shared types for the programmable opcode decoder: entry layout, FSM states
// and the power-on contents of the decode table.
package decode_pkg;

  localparam int BASE_ALU_W  = 8;
  localparam int BASE_CTRL_W = 8;

  typedef struct packed {
    logic                   illegal;
    logic                   last;
    logic [BASE_ALU_W-1:0]  alu;
    logic [BASE_CTRL_W-1:0] ctrl;
  } dec_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Later steps default to empty final steps; A, B and anything beyond the
  // base 16-opcode map are illegal.
  function automatic dec_entry_t default_entry(input int opc, input int step);
    dec_entry_t e;
    e      = '0;
    e.last = 1'b1;
    if (step == 0) begin
      case (opc)
        0:  e.alu = 8'h00;
        1:  e.alu = 8'hC0;
        2:  e.alu = 8'h20;
        3:  e.alu = 8'h2C;
        4:  e.alu = 8'h7C;
        5:  e.alu = 8'h02;
        6:  begin
              e.alu  = 8'h02;
              e.ctrl = 8'h40;
            end
        7:  e.ctrl = 8'h18;
        8:  e.ctrl = 8'h28;
        9:  e.ctrl = 8'hA0;
        12: e.ctrl = 8'h40;
        13: e.ctrl = 8'h04;
        14: e.ctrl = 8'h02;
        15: e.ctrl = 8'h01;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/decode_table.sv
// Run-time writable decode table: one flop per entry bit, synchronous reset
// back to the default map, one write port and one combinational read port.
module decode_table
  import decode_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int ALU_W  = 8,
  parameter int CTRL_W = 8,
  parameter int STEPS  = 2,
  parameter int STEP_W = 1,
  parameter int ENT_W  = ALU_W + CTRL_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [OPC_W-1:0]  wr_opc,
  input  logic [STEP_W-1:0] wr_step,
  input  logic [ENT_W-1:0]  wr_data,
  input  logic [OPC_W-1:0]  rd_opc,
  input  logic [STEP_W-1:0] rd_step,
  output logic [ENT_W-1:0]  rd_data
);

  localparam int DEPTH = 2 ** OPC_W;

  logic [ENT_W-1:0] mem [DEPTH][STEPS];

  function automatic logic [ENT_W-1:0] reset_value(input int opc, input int step);
    dec_entry_t d;
    d = default_entry(opc, step);
    return {d.illegal, d.last, ALU_W'(d.alu), CTRL_W'(d.ctrl)};
  endfunction

  // Reset has priority, so configuration writes are dropped while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < DEPTH; o++) begin
        for (int s = 0; s < STEPS; s++) begin
          mem[o][s] <= reset_value(o, s);
        end
      end
    end else if (we && (int'(wr_step) < STEPS)) begin
      mem[wr_opc][wr_step] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_step) < STEPS) begin
      rd_data = mem[rd_opc][rd_step];
    end
  end

endmodule

// File: rtl/decode_seq.sv
// Opcode-to-micro-step sequencer: accepts opcodes with valid/ready and
// presents each table step downstream, one registered step at a time.
module decode_seq
  import decode_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int ALU_W  = 8,
  parameter int CTRL_W = 8,
  parameter int STEPS  = 2,
  parameter int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPC_W-1:0]         in_opc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_W-1:0]         out_alu,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [STEP_W-1:0]        out_step,
  output logic                     out_last,
  output logic                     out_illegal,
  input  logic                     cfg_we,
  input  logic [OPC_W-1:0]         cfg_opc,
  input  logic [STEP_W-1:0]        cfg_step,
  input  logic [ALU_W+CTRL_W+1:0]  cfg_data
);

  localparam int ENT_W = ALU_W + CTRL_W + 2;

  state_t            state;
  state_t            next_state;
  logic [OPC_W-1:0]  cur_opc;
  logic [OPC_W-1:0]  rd_opc;
  logic [STEP_W-1:0] rd_step;
  logic [ENT_W-1:0]  rd_data;
  logic              accept;
  logic              advance;

  decode_table #(
    .OPC_W  (OPC_W),
    .ALU_W  (ALU_W),
    .CTRL_W (CTRL_W),
    .STEPS  (STEPS),
    .STEP_W (STEP_W),
    .ENT_W  (ENT_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_opc  (cfg_opc),
    .wr_step (cfg_step),
    .wr_data (cfg_data),
    .rd_opc  (rd_opc),
    .rd_step (rd_step),
    .rd_data (rd_data)
  );

  assign out_valid = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // out_last already folds in the forced-final conditions, so it alone
  // decides whether the current handshake ends the opcode.
  always_comb begin
    next_state = state;
    in_ready   = (state == IDLE) || ((state == ISSUE) && out_ready && out_last);
    accept     = in_valid && in_ready;
    advance    = (state == ISSUE) && out_ready && !out_last;
    rd_opc     = cur_opc;
    rd_step    = out_step + 1'b1;
    if (accept) begin
      next_state = ISSUE;
      rd_opc     = in_opc;
      rd_step    = '0;
    end else if (advance) begin
      next_state = ISSUE;
    end else if ((state == ISSUE) && out_ready) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_opc     <= '0;
      out_alu     <= '0;
      out_ctrl    <= '0;
      out_step    <= '0;
      out_last    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept || advance) begin
      cur_opc     <= rd_opc;
      out_step    <= rd_step;
      out_illegal <= rd_data[ENT_W-1];
      out_last    <= rd_data[ENT_W-1] | rd_data[ENT_W-2] |
                     (rd_step == STEP_W'(STEPS - 1));
      out_alu     <= rd_data[ALU_W+CTRL_W-1:CTRL_W];
      out_ctrl    <= rd_data[CTRL_W-1:0];
    end
  end

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: directed spec scenarios, a default-map
// vector table and a random run against a transaction-level reference model.
module tb_decode_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_alu;
  logic [7:0]  out_ctrl;
  logic        out_step;
  logic        out_last;
  logic        out_illegal;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_opc = '0;
  logic        cfg_step = 1'b0;
  logic [17:0] cfg_data = '0;

  always #5 clk = ~clk;

  decode_seq #(.OPC_W(4), .ALU_W(8), .CTRL_W(8), .STEPS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opc      (in_opc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu     (out_alu),
    .out_ctrl    (out_ctrl),
    .out_step    (out_step),
    .out_last    (out_last),
    .out_illegal (out_illegal),
    .cfg_we      (cfg_we),
    .cfg_opc     (cfg_opc),
    .cfg_step    (cfg_step),
    .cfg_data    (cfg_data)
  );

  typedef struct {
    logic [7:0] alu;
    logic [7:0] ctrl;
    bit         ill;
  } vec_t;

  typedef struct packed {
    logic       ill;
    logic       last;
    logic [7:0] alu;
    logic [7:0] ctrl;
  } ent_t;

  vec_t vecs[16];
  ent_t m_tbl[16][2];
  bit         m_busy = 1'b0;
  logic [3:0] m_opc = '0;
  bit         m_step = 1'b0;
  bit         m_last = 1'b0;
  bit         m_ill = 1'b0;
  logic [7:0] m_alu = '0;
  logic [7:0] m_ctrl = '0;
  int errors = 0;
  int checks = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int o, input logic [7:0] alu, input logic [7:0] ctrl, input bit ill);
    vecs[o].alu  = alu;
    vecs[o].ctrl = ctrl;
    vecs[o].ill  = ill;
  endtask

  task automatic modelDefaults();
    for (int o = 0; o < 16; o++) begin
      m_tbl[o][0] = {vecs[o].ill, 1'b1, vecs[o].alu, vecs[o].ctrl};
      m_tbl[o][1] = {1'b0, 1'b1, 8'h00, 8'h00};
    end
  endtask

  function automatic bit modelReady();
    return !m_busy || (out_ready && m_last);
  endfunction

  task automatic modelLoad(input logic [3:0] o, input bit s);
    ent_t e;
    e      = m_tbl[o][s];
    m_busy = 1'b1;
    m_opc  = o;
    m_step = s;
    m_ill  = e.ill;
    m_last = e.last || e.ill || (s == 1'b1);
    m_alu  = e.alu;
    m_ctrl = e.ctrl;
  endtask

  // Reads happen before the same-edge write lands, so a colliding write is seen next time.
  task automatic modelEdge();
    bit acc;
    bit adv;
    if (!rst_n) begin
      m_busy = 1'b0; m_opc = '0; m_step = 1'b0; m_last = 1'b0;
      m_ill = 1'b0; m_alu = '0; m_ctrl = '0;
      modelDefaults();
      return;
    end
    acc = in_valid && modelReady();
    adv = m_busy && out_ready && !m_last;
    if (acc) modelLoad(in_opc, 1'b0);
    else if (adv) modelLoad(m_opc, 1'b1);
    else if (m_busy && out_ready) m_busy = 1'b0;
    if (cfg_we) m_tbl[cfg_opc][cfg_step] = cfg_data;
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] opc, input bit ordy,
                               input bit we, input logic [3:0] copc, input bit cstep,
                               input logic [17:0] cdata, input bit rst);
    @(negedge clk);
    in_valid = v; in_opc = opc; out_ready = ordy;
    cfg_we = we; cfg_opc = copc; cfg_step = cstep; cfg_data = cdata;
    rst_n = rst;
    #1;
    if (rst) checkVal("in_ready", {31'b0, in_ready}, {31'b0, modelReady()});
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic offer(input logic [3:0] opc, input bit ordy);
    applyStimulus(1'b1, opc, ordy, 1'b0, 4'h0, 1'b0, 18'h0, 1'b1);
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, " valid"}, {31'b0, out_valid}, {31'b0, m_busy});
    if (m_busy) begin
      checkVal({name, " alu"}, {24'b0, out_alu}, {24'b0, m_alu});
      checkVal({name, " ctrl"}, {24'b0, out_ctrl}, {24'b0, m_ctrl});
      checkVal({name, " step"}, {31'b0, out_step}, {31'b0, m_step});
      checkVal({name, " last"}, {31'b0, out_last}, {31'b0, m_last});
      checkVal({name, " illegal"}, {31'b0, out_illegal}, {31'b0, m_ill});
    end
  endtask

  initial begin
    setVec(0, 8'h00, 8'h00, 0);  setVec(1, 8'hC0, 8'h00, 0);
    setVec(2, 8'h20, 8'h00, 0);  setVec(3, 8'h2C, 8'h00, 0);
    setVec(4, 8'h7C, 8'h00, 0);  setVec(5, 8'h02, 8'h00, 0);
    setVec(6, 8'h02, 8'h40, 0);  setVec(7, 8'h00, 8'h18, 0);
    setVec(8, 8'h00, 8'h28, 0);  setVec(9, 8'h00, 8'hA0, 0);
    setVec(10, 8'h00, 8'h00, 1); setVec(11, 8'h00, 8'h00, 1);
    setVec(12, 8'h00, 8'h40, 0); setVec(13, 8'h00, 8'h04, 0);
    setVec(14, 8'h00, 8'h02, 0); setVec(15, 8'h00, 8'h01, 0);
    modelDefaults();

    // Reset state; a cfg write during reset must be ignored.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 18'h0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b1, 4'h1, 1'b0, 18'h3FFFF, 1'b0);
    checkVal("rst valid", {31'b0, out_valid}, 32'd0);
    checkVal("rst alu", {24'b0, out_alu}, 32'd0);
    checkVal("rst ctrl", {24'b0, out_ctrl}, 32'd0);
    checkVal("rst step", {31'b0, out_step}, 32'd0);
    checkVal("rst last", {31'b0, out_last}, 32'd0);
    checkVal("rst illegal", {31'b0, out_illegal}, 32'd0);

    // Latency-one accept of opcode 1.
    offer(4'h1, 1'b1);
    checkVal("t1 valid", {31'b0, out_valid}, 32'd1);
    checkVal("t1 alu", {24'b0, out_alu}, 32'hC0);
    checkVal("t1 ctrl", {24'b0, out_ctrl}, 32'h00);
    checkVal("t1 step", {31'b0, out_step}, 32'd0);
    checkVal("t1 last", {31'b0, out_last}, 32'd1);
    checkVal("t1 in_ready", {31'b0, in_ready}, 32'd1);

    // Default map, back-to-back.
    for (int i = 0; i < 16; i++) begin
      offer(4'(i), 1'b1);
      checkVal($sformatf("vec%0d alu", i), {24'b0, out_alu}, {24'b0, vecs[i].alu});
      checkVal($sformatf("vec%0d ctrl", i), {24'b0, out_ctrl}, {24'b0, vecs[i].ctrl});
      checkVal($sformatf("vec%0d illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      checkVal($sformatf("vec%0d last", i), {31'b0, out_last}, 32'd1);
      checkVal($sformatf("vec%0d valid", i), {31'b0, out_valid}, 32'd1);
    end

    offer(4'h6, 1'b1);
    checkVal("t2 ctrl6", {24'b0, out_ctrl}, 32'h40);
    offer(4'h7, 1'b1);
    checkVal("t2 ctrl7", {24'b0, out_ctrl}, 32'h18);
    checkVal("t2 valid7", {31'b0, out_valid}, 32'd1);
    offer(4'h9, 1'b1);
    checkVal("t2 ctrl9", {24'b0, out_ctrl}, 32'hA0);
    checkVal("t2 valid9", {31'b0, out_valid}, 32'd1);

    // Two-step opcode 7.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0, 18'h00018, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b1, 18'h10008, 1'b1);
    offer(4'h7, 1'b1);
    checkVal("t3 s0 ctrl", {24'b0, out_ctrl}, 32'h18);
    checkVal("t3 s0 step", {31'b0, out_step}, 32'd0);
    checkVal("t3 s0 last", {31'b0, out_last}, 32'd0);
    checkVal("t3 s0 in_ready", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 18'h0, 1'b1);
    checkVal("t3 s1 ctrl", {24'b0, out_ctrl}, 32'h08);
    checkVal("t3 s1 step", {31'b0, out_step}, 32'd1);
    checkVal("t3 s1 last", {31'b0, out_last}, 32'd1);

    // Illegal opcode, then a stall.
    offer(4'hA, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 18'h0, 1'b1);
      checkVal($sformatf("t4 c%0d illegal", c), {31'b0, out_illegal}, 32'd1);
      checkVal($sformatf("t4 c%0d alu", c), {24'b0, out_alu}, 32'h00);
      checkVal($sformatf("t4 c%0d ctrl", c), {24'b0, out_ctrl}, 32'h00);
      checkVal($sformatf("t4 c%0d last", c), {31'b0, out_last}, 32'd1);
      checkVal($sformatf("t4 c%0d valid", c), {31'b0, out_valid}, 32'd1);
      if (c > 0) checkVal($sformatf("t4 c%0d in_ready", c), {31'b0, in_ready}, 32'd0);
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 18'h0, 1'b1);

    // Read-before-write on the accept edge.
    applyStimulus(1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b0, {1'b0, 1'b1, 8'h55, 8'h00}, 1'b1);
    checkVal("t5 old alu", {24'b0, out_alu}, 32'h20);
    offer(4'h2, 1'b1);
    checkVal("t5 new alu", {24'b0, out_alu}, 32'h55);

    // Reset mid-sequence restores defaults.
    offer(4'h7, 1'b1);
    checkVal("t6 pre last", {31'b0, out_last}, 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 18'h0, 1'b0);
    checkVal("t6 rst valid", {31'b0, out_valid}, 32'd0);
    offer(4'h7, 1'b1);
    checkVal("t6 ctrl", {24'b0, out_ctrl}, 32'h18);
    checkVal("t6 last", {31'b0, out_last}, 32'd1);
    offer(4'h2, 1'b1);
    checkVal("t6 alu2", {24'b0, out_alu}, 32'h20);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    18'($urandom), $urandom_range(0, 63) != 0);
      checkOutput("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
